aqp_vmode_switch: RTL and testbench
===================================

// Module: aqp_vmode_switch
// PURPOSE
//  Sequencer that drives the video clock mux select (0 = 28.63636 MHz, 1 = 25.175 MHz PLL).
//  Takes a mode request from the register file and makes the switch at a frame boundary, with video timing held in reset.
//  After a switch to PLL mode, waits for PLL lock; on lock timeout it reverts to mode 0 and flags an error.
//  Runs on the 28.63636 MHz system clock. Video-domain and PLL inputs are asynchronous and are synchronised inside the block.
// PARAMETERS
//  BLANK_CYCLES    16       clk cycles video_rst is held before the mux select changes
//  SETTLE_CYCLES   64       clk cycles after the select change before lock is checked / video released
//  LOCK_TIMEOUT    65535    clk cycles allowed for pll_locked to assert (mode 1 only)
//  VSYNC_TIMEOUT   1048575  clk cycles to wait for a vsync edge before switching anyway
// PORTS
//  clk             in   1   28.63636 MHz system clock
//  reset_n         in   1   async active-low reset
//  mode_req        in   1   requested video mode (level, clk domain)
//  vsync_async     in   1   video vsync, video_clk domain, active high
//  pll_locked_async in  1   PLL LOCKED, asynchronous
//  video_mode      out  1   BUFGMUX select; reset 0
//  video_rst       out  1   active-high reset to video timing/pixel logic; reset 1
//  busy            out  1   sequence in progress; reset 1
//  mode_cur        out  1   mode that is actually in effect; reset 0
//  lock_err        out  1   sticky: PLL lock timeout; reset 0; cleared when a new request is accepted
// BEHAVIOUR
//  - Async inputs go through a 2-FF synchroniser. vsync_rise = rising edge of the synchronised vsync (1 clk pulse).
//  - Single down-counter, 20 bits, shared by all timed states. It is loaded on state entry (value N-1) and
//    decrements every cycle. The state advances on the cycle the counter reads 0, so each timed state lasts exactly N cycles.
//  - FSM states:
//    RESET_HOLD: entered out of reset. video_mode=0, video_rst=1. Waits SETTLE_CYCLES, then goes to RELEASE.
//    IDLE: busy=0, video_rst=0. If mode_req != mode_cur: capture target=mode_req, clear lock_err, go to WAIT_VSYNC.
//    WAIT_VSYNC: go to BLANK on vsync_rise or when VSYNC_TIMEOUT expires.
//    BLANK: video_rst=1 from the first cycle of BLANK. Lasts BLANK_CYCLES, then go to SWITCH.
//    SWITCH: 1 cycle. video_mode<=target, then go to SETTLE.
//    SETTLE: lasts SETTLE_CYCLES. If target=0, go to RELEASE; otherwise go to WAIT_LOCK.
//    WAIT_LOCK: go to RELEASE when pll_locked (synchronised) is 1. On LOCK_TIMEOUT: lock_err<=1,
//      target<=0, go to SWITCH. The revert path always passes through SETTLE again.
//    RELEASE: 1 cycle. mode_cur<=video_mode, video_rst<=0, go to IDLE.
//  - busy=1 in every state except IDLE. It is a registered output and changes on the same edge as the state.
//  - mode_req is sampled only in IDLE. Changes during a sequence are ignored until IDLE is re-entered.
//    A request equal to mode_cur is a no-op.
//  - If mode_req=1 and lock_err=1, a new request is not started until mode_req has gone to 0 and back to 1.
//    This prevents endless retries.
//  - video_mode changes only in SWITCH, and only while video_rst=1.
//  - reset_n low at any point: all outputs go immediately to their reset values and the FSM returns to RESET_HOLD.
//  - vsync_rise in any state other than WAIT_VSYNC is ignored.
// STRUCTURE
//  - Shared package/header: state encoding localparams (RESET_HOLD..RELEASE, 3-bit) and the counter width (20).
//  - Sub-module aqp_sync2: 2-FF synchroniser with async active-low reset to 0. Instantiated twice.
//  - Top level: the FSM, the shared counter, and the output registers.
// TESTING
//  1 Reset release -> video_rst=1 and busy=1 for exactly SETTLE_CYCLES+1 clks, then IDLE with
//    video_mode=0 and mode_cur=0.
//  2 mode_req 0->1, vsync pulse 100 clks later, pll_locked high 10 clks after SWITCH -> video_rst rises 2-3 clks
//    after vsync (synchroniser), video_mode=1 after BLANK_CYCLES, mode_cur=1, lock_err=0.
//  3 mode_req->1 with pll_locked held 0 -> after LOCK_TIMEOUT, lock_err=1, video_mode back to 0, mode_cur=0,
//    busy=0, no retry. Toggle mode_req 0->1 -> lock_err clears and a new sequence starts.
//  4 mode_req->1 with no vsync -> BLANK entered after exactly VSYNC_TIMEOUT clks (test with parameter overridden
//    to 1000); the switch then completes.
//  5 mode_req toggled during BLANK -> ignored; after IDLE is reached, the new request starts a fresh sequence.
//  6 reset_n pulsed low during WAIT_LOCK -> outputs go async to video_mode=0, video_rst=1, lock_err=0; then the
//    scenario-1 sequence follows.

Source files
------------

// File: rtl/aqp_vmode_switch_pkg.sv
// Shared definitions for the video mode switch sequencer: state encoding,
// counter width and a helper to compute counter load values.
package aqp_vmode_switch_pkg;

  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    IDLE       = 3'd1,
    WAIT_VSYNC = 3'd2,
    BLANK      = 3'd3,
    SWITCH     = 3'd4,
    SETTLE     = 3'd5,
    WAIT_LOCK  = 3'd6,
    RELEASE    = 3'd7
  } state_e;

  // A timed state that must last n cycles loads n-1 and leaves when the count reads 0.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/aqp_sync2.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
module aqp_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  // Metastability filter: two back-to-back flops in the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/aqp_vmode_switch.sv
// Video clock mux sequencer. Switches the BUFGMUX select at a frame boundary
// with video timing held in reset, waits for PLL lock when moving to the PLL
// clock, and falls back to mode 0 with a sticky error if lock never arrives.
//
//  state      | meaning
//  RESET_HOLD | post-reset settle, video held in reset
//  IDLE       | stable, watching for a mode request
//  WAIT_VSYNC | waiting for a frame boundary (or timeout)
//  BLANK      | video held in reset before the select changes
//  SWITCH     | select takes the target value (1 cycle)
//  SETTLE     | clock settling after the select change
//  WAIT_LOCK  | waiting for PLL lock (target mode 1 only)
//  RELEASE    | commit mode_cur, release video reset (1 cycle)
module aqp_vmode_switch
  import aqp_vmode_switch_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned VSYNC_TIMEOUT = 1048575
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mode_req,
  input  logic vsync_async,
  input  logic pll_locked_async,
  output logic video_mode,
  output logic video_rst,
  output logic busy,
  output logic mode_cur,
  output logic lock_err
);

  logic             vsync_s;
  logic             pll_locked_s;
  logic             vsync_prev_q;
  logic             vsync_rise;
  logic             cnt_zero;
  logic             start_req;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             target_q;
  logic             rearm_q;
  logic             video_mode_q;
  logic             video_rst_q;
  logic             busy_q;
  logic             mode_cur_q;
  logic             lock_err_q;

  aqp_sync2 u_sync_vsync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (vsync_async),
    .q_o     (vsync_s)
  );

  aqp_sync2 u_sync_lock (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (pll_locked_async),
    .q_o     (pll_locked_s)
  );

  // Delayed copy of the synchronised vsync for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vsync_prev_q <= 1'b0;
    else          vsync_prev_q <= vsync_s;
  end

  assign vsync_rise = vsync_s & ~vsync_prev_q;
  assign cnt_zero   = (cnt_q == '0);

  // A request that timed out on lock is not retried until mode_req has been
  // seen low in IDLE (rearm_q), otherwise a held request would loop forever.
  assign start_req = (mode_req != mode_cur_q) && !(lock_err_q && mode_req && !rearm_q);

  // Sequencer FSM with the shared down-counter and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RESET_HOLD;
      cnt_q        <= cnt_load(SETTLE_CYCLES);
      target_q     <= 1'b0;
      rearm_q      <= 1'b0;
      video_mode_q <= 1'b0;
      video_rst_q  <= 1'b1;
      busy_q       <= 1'b1;
      mode_cur_q   <= 1'b0;
      lock_err_q   <= 1'b0;
    end else begin
      if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
      case (state_q)
        RESET_HOLD: begin
          if (cnt_zero) state_q <= RELEASE;
        end
        IDLE: begin
          if (!mode_req) rearm_q <= 1'b1;
          if (start_req) begin
            target_q   <= mode_req;
            lock_err_q <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= cnt_load(VSYNC_TIMEOUT);
            state_q    <= WAIT_VSYNC;
          end
        end
        WAIT_VSYNC: begin
          if (vsync_rise || cnt_zero) begin
            video_rst_q <= 1'b1;
            cnt_q       <= cnt_load(BLANK_CYCLES);
            state_q     <= BLANK;
          end
        end
        BLANK: begin
          if (cnt_zero) state_q <= SWITCH;
        end
        SWITCH: begin
          video_mode_q <= target_q;
          cnt_q        <= cnt_load(SETTLE_CYCLES);
          state_q      <= SETTLE;
        end
        SETTLE: begin
          if (cnt_zero) begin
            if (target_q) begin
              cnt_q   <= cnt_load(LOCK_TIMEOUT);
              state_q <= WAIT_LOCK;
            end else begin
              state_q <= RELEASE;
            end
          end
        end
        WAIT_LOCK: begin
          if (pll_locked_s) begin
            state_q <= RELEASE;
          end else if (cnt_zero) begin
            lock_err_q <= 1'b1;
            target_q   <= 1'b0;
            rearm_q    <= 1'b0;
            state_q    <= SWITCH;
          end
        end
        RELEASE: begin
          mode_cur_q  <= video_mode_q;
          video_rst_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= RESET_HOLD;
      endcase
    end
  end

  assign video_mode = video_mode_q;
  assign video_rst  = video_rst_q;
  assign busy       = busy_q;
  assign mode_cur   = mode_cur_q;
  assign lock_err   = lock_err_q;

endmodule

// File: tb/tb_aqp_vmode_switch.sv
// Self-checking bench for aqp_vmode_switch: directed vector table, hand
// sequences for reset/toggle corner cases, and randomized scenarios checked
// against a timeline model derived from the sequencing rules.
module tb_aqp_vmode_switch;

  localparam int BL = 16;
  localparam int ST = 64;
  localparam int LT = 300;
  localparam int VT = 1000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mode_req = 1'b0;
  logic vsync_async = 1'b0;
  logic pll_locked_async = 1'b0;
  logic video_mode, video_rst, busy, mode_cur, lock_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aqp_vmode_switch #(
    .BLANK_CYCLES  (BL),
    .SETTLE_CYCLES (ST),
    .LOCK_TIMEOUT  (LT),
    .VSYNC_TIMEOUT (VT)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mode_req         (mode_req),
    .vsync_async      (vsync_async),
    .pll_locked_async (pll_locked_async),
    .video_mode       (video_mode),
    .video_rst        (video_rst),
    .busy             (busy),
    .mode_cur         (mode_cur),
    .lock_err         (lock_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // video_mode may only move while video timing is held in reset
  logic vm_prev = 1'b0;
  always @(negedge clk) begin
    if (video_mode !== vm_prev) chkb("vmode_change_under_rst", video_rst, 1'b1);
    vm_prev = video_mode;
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit start;
    int blank;
    int idle;
    bit cur;
    bit err;
  } exp_t;

  bit m_cur = 1'b0;
  bit m_err = 1'b0;
  bit m_rearm = 1'b1;

  // Edge numbers are relative to the edge at which mode_req is applied (edge 0).
  task automatic model_step(input bit req, input int dv, input int dl, output exp_t e);
    int b, w, x;
    if (!req) m_rearm = 1'b1;
    e.start = (req != m_cur) && !(m_err && req && !m_rearm);
    e.blank = -1;
    e.idle  = -1;
    e.cur   = m_cur;
    e.err   = m_err;
    if (e.start) begin
      b = (dv >= 0 && dv + 3 <= VT + 1) ? dv + 3 : VT + 1;
      e.blank = b;
      if (!req) begin
        e.idle = b + BL + 1 + ST + 1;
        e.cur  = 1'b0;
        e.err  = 1'b0;
      end else begin
        w = b + BL + 1 + ST;
        x = (dl + 3 > w + 1) ? dl + 3 : w + 1;
        if (dl >= 0 && x <= w + LT) begin
          e.idle = x + 1;
          e.cur  = 1'b1;
          e.err  = 1'b0;
        end else begin
          e.idle  = w + LT + 1 + ST + 1;
          e.cur   = 1'b0;
          e.err   = 1'b1;
          m_rearm = 1'b0;
        end
      end
      m_cur = e.cur;
      m_err = e.err;
    end
  endtask

  // ---------------- stimulus driver ----------------
  // Caller is aligned 1 ns after a posedge (edge 0). Returns aligned likewise.
  task automatic run_seq(input bit req, input int dv, input int dl, input int toggle_k,
                         input int budget, output int o_blank, output int o_medge,
                         output int o_idle, output bit o_started);
    logic vm0;
    vm0 = video_mode;
    o_blank = -1;
    o_medge = -1;
    o_idle = -1;
    o_started = 1'b0;
    for (int k = 0; k <= budget; k++) begin
      if (k == 0) mode_req = req;
      if (k == toggle_k) mode_req = ~mode_req;
      vsync_async = (dv >= 0 && k >= dv && k < dv + 4);
      pll_locked_async = (dl >= 0 && k >= dl);
      @(negedge clk);
      if (o_blank < 0 && video_rst) o_blank = k;
      if (o_medge < 0 && video_mode !== vm0) o_medge = k;
      if (busy) o_started = 1'b1;
      if (o_started && !busy && o_idle < 0) o_idle = k;
      @(posedge clk);
      #1;
      if (o_idle >= 0) break;
    end
  endtask

  task automatic check_final(input string tag, input exp_t e);
    chkb({tag, "_mode_cur"}, mode_cur, e.cur);
    chkb({tag, "_lock_err"}, lock_err, e.err);
    chkb({tag, "_video_mode"}, video_mode, e.cur);
    chkb({tag, "_video_rst"}, video_rst, 1'b0);
    chkb({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic scenario(input string tag, input bit req, input int dv, input int dl, input exp_t e);
    int ob, om, oi;
    bit os;
    run_seq(req, dv, dl, -1, e.start ? e.idle + 5 : 10, ob, om, oi, os);
    chkb({tag, "_started"}, os, e.start);
    if (e.start) begin
      chk({tag, "_blank_edge"}, ob, e.blank);
      chk({tag, "_vmode_edge"}, om, e.blank + BL + 1);
      chk({tag, "_idle_edge"}, oi, e.idle);
    end
    check_final(tag, e);
  endtask

  // Reset release: busy and video_rst stay high for SETTLE_CYCLES+1 clocks
  task automatic check_reset(input string tag);
    int cnt;
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy && video_rst) cnt++;
      else break;
    end
    chk({tag, "_hold_cycles"}, cnt, ST + 1);
    @(posedge clk);
    #1;
    chkb({tag, "_idle_vmode"}, video_mode, 1'b0);
    chkb({tag, "_idle_cur"}, mode_cur, 1'b0);
    chkb({tag, "_idle_busy"}, busy, 1'b0);
    chkb({tag, "_idle_vrst"}, video_rst, 1'b0);
    chkb({tag, "_idle_err"}, lock_err, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit req;
    int dv;
    int dl;
    bit st;
    int blank;
    int idle;
    bit cur;
    bit err;
  } vec_t;

  vec_t tbl[12];

  initial begin
    exp_t e;
    int ob, om, oi, cyc;
    bit os;

    tbl[0]  = '{1'b1,  100,  129, 1'b1,  103,  186, 1'b1, 1'b0}; // switch to PLL, lock 10 clks after SWITCH
    tbl[1]  = '{1'b0,    5,   -1, 1'b1,    8,   90, 1'b0, 1'b0}; // back to mode 0
    tbl[2]  = '{1'b0,    5,   -1, 1'b0,   -1,   -1, 1'b0, 1'b0}; // same mode: no-op
    tbl[3]  = '{1'b1,   20,   -1, 1'b1,   23,  470, 1'b0, 1'b1}; // lock timeout, revert
    tbl[4]  = '{1'b1,   20,   -1, 1'b0,   -1,   -1, 1'b0, 1'b1}; // held request: no retry
    tbl[5]  = '{1'b0,   -1,   -1, 1'b0,   -1,   -1, 1'b0, 1'b1}; // drop request, error stays
    tbl[6]  = '{1'b1,   -1,    0, 1'b1, 1001, 1084, 1'b1, 1'b0}; // rearmed, vsync timeout path
    tbl[7]  = '{1'b1,   30,    0, 1'b0,   -1,   -1, 1'b1, 1'b0}; // same mode: no-op
    tbl[8]  = '{1'b0,    0,   -1, 1'b1,    3,   85, 1'b0, 1'b0}; // vsync with the request
    tbl[9]  = '{1'b1,   50,  431, 1'b1,   53,  435, 1'b1, 1'b0}; // lock on the last allowed cycle
    tbl[10] = '{1'b0,   10,   -1, 1'b1,   13,   95, 1'b0, 1'b0};
    tbl[11] = '{1'b1,   50,  432, 1'b1,   53,  500, 1'b0, 1'b1}; // lock one cycle too late

    // Reset values while reset_n is held low
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_video_mode", video_mode, 1'b0);
    chkb("rst_video_rst", video_rst, 1'b1);
    chkb("rst_busy", busy, 1'b1);
    chkb("rst_mode_cur", mode_cur, 1'b0);
    chkb("rst_lock_err", lock_err, 1'b0);
    check_reset("por");

    foreach (tbl[i]) begin
      e.start = tbl[i].st;
      e.blank = tbl[i].blank;
      e.idle  = tbl[i].idle;
      e.cur   = tbl[i].cur;
      e.err   = tbl[i].err;
      scenario($sformatf("tbl%0d", i), tbl[i].req, tbl[i].dv, tbl[i].dl, e);
    end

    // Toggle during BLANK is ignored; the new level starts a fresh sequence after IDLE
    run_seq(1'b0, -1, -1, -1, 10, ob, om, oi, os);
    chkb("t5_pre_nostart", os, 1'b0);
    run_seq(1'b1, 0, 0, 6, 200, ob, om, oi, os);
    chk("t5_blank_edge", ob, 3);
    chk("t5_idle_edge", oi, 86);
    chkb("t5_first_cur", mode_cur, 1'b1);
    chkb("t5_restart_busy", busy, 1'b1);
    cyc = 0;
    while (busy && cyc < 1500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("t5_second_len", cyc, VT + BL + 1 + ST + 1);
    chkb("t5_second_cur", mode_cur, 1'b0);
    m_cur = 1'b0;
    m_err = 1'b0;
    m_rearm = 1'b1;

    // Randomized scenarios against the model
    for (int r = 0; r < 14; r++) begin
      bit req;
      int dv, dl, sel;
      req = ($urandom_range(0, 3) == 0) ? m_cur : ~m_cur;
      sel = $urandom_range(0, 3);
      if (sel == 0)      dv = -1;
      else if (sel == 1) dv = VT - 4 + int'($urandom_range(0, 6));
      else               dv = $urandom_range(0, 150);
      sel = $urandom_range(0, 2);
      if (!req || sel == 0) dl = -1;
      else if (sel == 1)    dl = $urandom_range(0, 400);
      else                  dl = $urandom_range(0, 1500);
      model_step(req, dv, dl, e);
      scenario($sformatf("rnd%0d", r), req, dv, dl, e);
    end

    // Reset pulsed during WAIT_LOCK
    model_step(1'b0, 0, -1, e);
    scenario("t6_prep", 1'b0, 0, -1, e);
    mode_req = 1'b1;
    pll_locked_async = 1'b0;
    vsync_async = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    vsync_async = 1'b0;
    repeat (96) begin
      @(posedge clk);
      #1;
    end
    chkb("t6_pre_busy", busy, 1'b1);
    chkb("t6_pre_vmode", video_mode, 1'b1);
    chkb("t6_pre_vrst", video_rst, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chkb("t6_async_vmode", video_mode, 1'b0);
    chkb("t6_async_vrst", video_rst, 1'b1);
    chkb("t6_async_err", lock_err, 1'b0);
    chkb("t6_async_busy", busy, 1'b1);
    mode_req = 1'b0;
    @(posedge clk);
    #1;
    check_reset("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
